// File: rtl/cpu5_ifu_pkg.sv
// Shared CPU5 defines plus the small set of constants/helpers used by the fetch unit.
// Pure declarations: no logic, no latency, no flow control.
`ifndef CPU5_DEFINES
`define CPU5_DEFINES
`define CPU5_XLEN 32
`define CPU5_INSTR_BYTES 4
`endif

package cpu5_ifu_pkg;

    localparam int unsigned INSTR_BYTES = `CPU5_INSTR_BYTES;

    // Counters sized to hold the full range 0..depth inclusive.
    function automatic int fq_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cpu5_fifo.sv
// Generic synchronous FIFO with flush; head is a registered entry (no bypass).
// Latency: push visible at head the cycle after. Backpressure: push ignored when full unless popping.
module cpu5_fifo #(
    parameter int               WIDTH   = 64,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty     = (cnt == '0);
    assign full      = (cnt == (AW+1)'(DEPTH));
    assign count     = cnt;
    assign head_data = mem[rptr];

    // A simultaneous pop frees the slot, so a full queue can still accept.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RST_VAL;
            end
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/cpu5_prims.sv
// cpu5_dff: enable flop with async active-low reset. Latency 1 cycle.
// cpu5_add: wrapping combinational adder. Latency 0. Neither has flow control.
module cpu5_dff #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

module cpu5_add #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/cpu5_ifu.sv
// Instruction fetch unit: credit-limited fetch requests, in-order responses into a fetch queue.
// Latency: response in cycle N is presented to decode in N+1. Backpressure: decode stall holds the
// queue head; requests stop once outstanding + queued reaches FQ_DEPTH.
`ifndef CPU5_DEFINES
`define CPU5_DEFINES
`define CPU5_XLEN 32
`define CPU5_INSTR_BYTES 4
`endif

module cpu5_ifu import cpu5_ifu_pkg::*; #(
    parameter int              XLEN     = `CPU5_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc
);

    localparam int              CW         = fq_cnt_w(FQ_DEPTH);
    localparam logic [CW:0]     CREDIT_LIM = (CW+1)'(FQ_DEPTH);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));

    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   fetch_pc_inc;
    logic [XLEN-1:0]   fetch_pc_d;
    logic [XLEN-1:0]   rsp_pc;
    logic [XLEN-1:0]   rsp_pc_inc;
    logic [XLEN-1:0]   rsp_pc_d;
    logic [XLEN-1:0]   redirect_aligned;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     outstanding_nxt;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     drop_cnt_nxt;
    logic [CW-1:0]     fq_count;
    logic [CW:0]       credits_used;
    logic              req_hs;
    logic              rsp_drop;
    logic              fq_push;
    logic              fq_pop;
    logic              fq_empty;
    logic              unused_fq_full;
    logic [2*XLEN-1:0] fq_head;

    assign redirect_aligned = redirect_pc & ALIGN_MASK;

    // Every outstanding request already owns a queue slot, so a response never finds the queue full.
    assign credits_used   = {1'b0, outstanding} + {1'b0, fq_count};
    assign imem_req_valid = reset && !redirect_valid && (credits_used < CREDIT_LIM);
    assign imem_req_addr  = fetch_pc;
    assign req_hs         = imem_req_valid & imem_req_ready;

    assign rsp_drop = redirect_valid | (drop_cnt != '0);
    assign fq_push  = imem_rsp_valid & ~rsp_drop;
    assign fq_pop   = dec_valid & dec_ready & ~redirect_valid;

    always_comb begin
        outstanding_nxt = outstanding;
        case ({req_hs, imem_rsp_valid})
            2'b10:   outstanding_nxt = outstanding + 1'b1;
            2'b01:   outstanding_nxt = outstanding - 1'b1;
            default: outstanding_nxt = outstanding;
        endcase

        // On redirect everything still in flight after this cycle is stale.
        drop_cnt_nxt = drop_cnt;
        if (redirect_valid) begin
            drop_cnt_nxt = outstanding_nxt;
        end else if (imem_rsp_valid && (drop_cnt != '0)) begin
            drop_cnt_nxt = drop_cnt - 1'b1;
        end
    end

    assign fetch_pc_d = redirect_valid ? redirect_aligned : fetch_pc_inc;
    assign rsp_pc_d   = redirect_valid ? redirect_aligned : rsp_pc_inc;

    cpu5_add #(.WIDTH(XLEN)) u_fetch_inc (
        .a   (fetch_pc),
        .b   (PC_STEP),
        .sum (fetch_pc_inc)
    );

    cpu5_add #(.WIDTH(XLEN)) u_rsp_inc (
        .a   (rsp_pc),
        .b   (PC_STEP),
        .sum (rsp_pc_inc)
    );

    cpu5_dff #(.WIDTH(XLEN), .RST_VAL(RESET_PC)) u_fetch_pc (
        .clk   (clk),
        .reset (reset),
        .en    (redirect_valid | req_hs),
        .d     (fetch_pc_d),
        .q     (fetch_pc)
    );

    cpu5_dff #(.WIDTH(XLEN), .RST_VAL(RESET_PC)) u_rsp_pc (
        .clk   (clk),
        .reset (reset),
        .en    (redirect_valid | fq_push),
        .d     (rsp_pc_d),
        .q     (rsp_pc)
    );

    cpu5_dff #(.WIDTH(CW), .RST_VAL('0)) u_outstanding (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (outstanding_nxt),
        .q     (outstanding)
    );

    cpu5_dff #(.WIDTH(CW), .RST_VAL('0)) u_drop_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (drop_cnt_nxt),
        .q     (drop_cnt)
    );

    cpu5_fifo #(
        .WIDTH   (2*XLEN),
        .DEPTH   (FQ_DEPTH),
        .RST_VAL ({RESET_PC, {XLEN{1'b0}}})
    ) u_fq (
        .clk       (clk),
        .reset     (reset),
        .push      (fq_push),
        .push_data ({rsp_pc, imem_rsp_data}),
        .pop       (fq_pop),
        .flush     (redirect_valid),
        .head_data (fq_head),
        .full      (unused_fq_full),
        .empty     (fq_empty),
        .count     (fq_count)
    );

    assign dec_valid = ~fq_empty;
    assign dec_pc    = fq_head[2*XLEN-1:XLEN];
    assign dec_instr = fq_head[XLEN-1:0];

endmodule

// File: tb/tb_cpu5_ifu.sv
// Directed bench for cpu5_ifu: three instances (depth 2 at PC 0, depth 4 at PC 0, depth 2 at FFFF_FFF8)
// share reset/decode/redirect stimulus; each has its own fixed-latency in-order memory model.
`timescale 1ns/1ps

module tb_cpu5_ifu;

    localparam int          N   = 3;
    localparam logic [31:0] KEY = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rdy;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic        dec_rdy;

    logic        req_vld   [N];
    logic [31:0] req_addr  [N];
    logic        rsp_vld   [N];
    logic [31:0] rsp_dat   [N];
    logic        dec_vld   [N];
    logic [31:0] dec_instr [N];
    logic [31:0] dec_pc    [N];

    logic        pend_vld  [N][4];
    logic [31:0] pend_addr [N][4];
    int          hs_cnt    [N];
    logic [31:0] wrap_exp  [3];

    int          lat;
    int          errors = 0;
    int          checks = 0;
    int          pops;
    int          seen;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        cpu5_ifu #(
            .XLEN     (32),
            .RESET_PC (g == 2 ? 32'hFFFF_FFF8 : 32'h0000_0000),
            .FQ_DEPTH (g == 1 ? 4 : 2)
        ) u_dut (
            .clk            (clk),
            .reset          (reset),
            .imem_req_valid (req_vld[g]),
            .imem_req_ready (mem_rdy),
            .imem_req_addr  (req_addr[g]),
            .imem_rsp_valid (rsp_vld[g]),
            .imem_rsp_data  (rsp_dat[g]),
            .redirect_valid (redirect_vld),
            .redirect_pc    (redirect_pc),
            .dec_valid      (dec_vld[g]),
            .dec_ready      (dec_rdy),
            .dec_instr      (dec_instr[g]),
            .dec_pc         (dec_pc[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mem_clear();
        for (int d = 0; d < N; d++) begin
            for (int k = 0; k < 4; k++) begin
                pend_vld[d][k]  = 1'b0;
                pend_addr[d][k] = '0;
            end
            rsp_vld[d] = 1'b0;
            rsp_dat[d] = '0;
        end
    endtask

    // Record this cycle's handshakes, advance one clock, present responses due in the new cycle.
    task automatic cyc();
        #1;
        for (int d = 0; d < N; d++) begin
            logic hs;
            hs = req_vld[d] & mem_rdy & reset;
            if (hs) hs_cnt[d]++;
            for (int k = 0; k < 3; k++) begin
                pend_vld[d][k]  = pend_vld[d][k+1];
                pend_addr[d][k] = pend_addr[d][k+1];
            end
            pend_vld[d][3] = 1'b0;
            if (hs) begin
                pend_vld[d][lat-1]  = 1'b1;
                pend_addr[d][lat-1] = req_addr[d];
            end
        end
        @(posedge clk);
        @(negedge clk);
        redirect_vld = 1'b0;
        for (int d = 0; d < N; d++) begin
            rsp_vld[d] = pend_vld[d][0];
            rsp_dat[d] = pend_addr[d][0] ^ KEY;
        end
        #1;
    endtask

    task automatic do_reset(input int l, input logic rdy);
        reset        = 1'b0;
        redirect_vld = 1'b0;
        mem_rdy      = 1'b1;
        mem_clear();
        lat     = l;
        dec_rdy = rdy;
        repeat (2) cyc();
        for (int d = 0; d < N; d++) hs_cnt[d] = 0;
        reset = 1'b1;
        #1;
    endtask

    task automatic wait_dec(input int d);
        for (int k = 0; k < 20 && !dec_vld[d]; k++) cyc();
    endtask

    initial begin
        reset        = 1'b0;
        mem_rdy      = 1'b1;
        dec_rdy      = 1'b0;
        redirect_vld = 1'b0;
        redirect_pc  = '0;
        lat          = 1;
        wrap_exp[0]  = 32'hFFFF_FFF8;
        wrap_exp[1]  = 32'hFFFF_FFFC;
        wrap_exp[2]  = 32'h0000_0000;
        mem_clear();
        for (int d = 0; d < N; d++) hs_cnt[d] = 0;
        @(negedge clk);
        #1;

        check("rst_req_vld", req_vld[0], 0);
        check("rst_dec_vld", dec_vld[0], 0);
        check("rst_req_addr", req_addr[0], 32'h0);
        check("rst_dec_instr", dec_instr[0], 32'h0);
        check("rst_wrap_addr", req_addr[2], 32'hFFFF_FFF8);
        check("rst_wrap_dec_pc", dec_pc[2], 32'hFFFF_FFF8);

        // Streaming on the depth-4 instance, wrap on the high-PC instance.
        repeat (2) cyc();
        dec_rdy = 1'b1;
        reset   = 1'b1;
        #1;
        check("first_req_vld", req_vld[1], 1);
        check("first_req_addr", req_addr[1], 32'h0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("stream_vld_c%0d", k), dec_vld[1], (k >= 2));
            if (k >= 2 && k <= 5) check($sformatf("stream_pc_c%0d", k), dec_pc[1], 32'((k - 2) * 4));
            if (k == 2) check("stream_instr", dec_instr[1], KEY);
            if (dec_vld[2] && seen < 3) begin
                check($sformatf("wrap_pc%0d", seen), dec_pc[2], wrap_exp[seen]);
                seen++;
            end
            cyc();
        end
        check("wrap_pops", seen, 3);

        // Asynchronous reset asserted between clock edges.
        #2;
        reset = 1'b0;
        mem_clear();
        #1;
        check("arst_req_vld", req_vld[1], 0);
        check("arst_dec_vld", dec_vld[1], 0);
        check("arst_req_addr", req_addr[1], 32'h0);
        check("arst_dec_pc", dec_pc[1], 32'h0);
        check("arst_dec_instr", dec_instr[1], 32'h0);
        check("arst_wrap_dec_pc", dec_pc[2], 32'hFFFF_FFF8);

        // Backpressure on the depth-2 instance.
        do_reset(1, 1'b0);
        check("restart_req_vld", req_vld[0], 1);
        check("restart_req_addr", req_addr[0], 32'h0);
        for (int k = 0; k < 10; k++) begin
            if (k >= 2) check($sformatf("bp_hold_pc_c%0d", k), dec_pc[0], 32'h0);
            cyc();
        end
        check("bp_reqs", hs_cnt[0], 2);
        check("bp_hold_vld", dec_vld[0], 1);
        check("bp_hold_instr", dec_instr[0], KEY);
        dec_rdy = 1'b1;
        #1;
        exp_pc = 32'h0;
        pops   = 0;
        for (int k = 0; k < 30 && pops < 4; k++) begin
            if (dec_vld[0]) begin
                check($sformatf("bp_seq%0d", pops), dec_pc[0], exp_pc);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            cyc();
        end
        check("bp_pops", pops, 4);

        // Redirect with two requests in flight at 3-cycle latency.
        do_reset(3, 1'b1);
        repeat (2) cyc();
        redirect_vld = 1'b1;
        redirect_pc  = 32'h0000_0103;
        #1;
        check("redir_withdraw", req_vld[0], 0);
        cyc();
        check("redir_addr", req_addr[0], 32'h0000_0100);
        check("redir_empty", dec_vld[0], 0);
        wait_dec(0);
        check("redir_pc", dec_pc[0], 32'h0000_0100);
        check("redir_instr", dec_instr[0], 32'h0000_0100 ^ KEY);
        cyc();
        wait_dec(0);
        check("redir_pc_next", dec_pc[0], 32'h0000_0104);

        // Redirect colliding with a response and a decode pop.
        do_reset(1, 1'b1);
        repeat (2) cyc();
        check("col_pre_vld", dec_vld[0], 1);
        redirect_vld = 1'b1;
        redirect_pc  = 32'h0000_0200;
        #1;
        cyc();
        check("col_empty", dec_vld[0], 0);
        check("col_req_vld", req_vld[0], 1);
        check("col_req_addr", req_addr[0], 32'h0000_0200);
        wait_dec(0);
        check("col_pc", dec_pc[0], 32'h0000_0200);
        cyc();
        wait_dec(0);
        check("col_pc_next", dec_pc[0], 32'h0000_0204);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
